axi_mem_slave: RTL and testbench
================================

Name: axi_mem_slave

Overview:
- AXI4 memory-mapped responder: accepts write/read bursts from an AXI master and services them from an internal byte-addressable memory.
- It is the slave end of the master VIP stimulus path, and lets benches run without a passthrough/slave VIP in runtime-slave mode.
- Independent write and read engines; one outstanding transaction per direction.

Parameters:
- ADDR_W, 16, AXI address width (byte address).
- DATA_W, 32, data width; 32 or 64 only; beat size is fixed at DATA_W/8 bytes.
- ID_W, 4, AXI ID width.
- MEM_DEPTH, 1024, memory depth in DATA_W words; valid byte range is 0 .. MEM_DEPTH*DATA_W/8-1.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- awid/awaddr  in  ID_W/ADDR_W  write address channel ID and address
- awlen  in  8  write burst length minus 1
- awburst  in  2  write burst type
- awvalid/awready  in/out  1  write address handshake
- wdata/wstrb  in  DATA_W/DATA_W/8  write data and byte strobes
- wlast  in  1  last write beat
- wvalid/wready  in/out  1  write data handshake
- bid/bresp  out  ID_W/2  write response ID and code
- bvalid/bready  out/in  1  write response handshake
- arid/araddr/arlen/arburst  in  ID_W/ADDR_W/8/2  read address channel
- arvalid/arready  in/out  1  read address handshake
- rid/rdata/rresp  out  ID_W/DATA_W/2  read data channel
- rlast  out  1  last read beat
- rvalid/rready  out/in  1  read data handshake

Behaviour:
- Interface: one clock, aclk. Reset areset is synchronous and active-high.
- Reset values: awready=1, arready=1; wready, bvalid, rvalid and rlast=0; bresp, rresp, rdata, bid and rid=0. Memory contents are not cleared.
- Reset mid-burst: both FSMs return to IDLE the next cycle. Partial writes already committed stay in memory.
- Write FSM:
  - W_IDLE (awready=1): on awvalid&&awready, latch id, addr, len and burst; go to W_DATA.
  - W_DATA (wready=1): each w handshake writes the strobed bytes to the current word in the same clock edge, then advances the address. Beat count awlen+1 ends the burst, not wlast; go to W_RESP.
  - W_RESP (bvalid=1): hold bid/bresp until bready; go to W_IDLE. awready reasserts the cycle after the B handshake.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch the request; go to R_DATA.
  - R_DATA: rvalid is registered. The first beat is valid 1 cycle after the AR handshake (memory read latency 1). rdata, rresp and rlast are held stable while rvalid&&!rready. The next beat is presented the cycle after each handshake; no back-to-back pipelining is required. rlast=1 on beat arlen+1; after that handshake go to R_IDLE.
- Address arithmetic:
  - word index = addr[ADDR_W-1:log2(DATA_W/8)]; the low address bits are ignored (aligned access only).
  - INCR (2'b01): index+1 per beat. FIXED (2'b00): index constant.
  - WRAP (2'b10) and reserved (2'b11): burst fully handshaken, no memory writes, SLVERR on B or on every R beat.
- Responses:
  - Any beat with index>=MEM_DEPTH is DECERR (2'b11). That write beat is dropped; that read beat returns rdata=0.
  - bresp is the worst of the burst (DECERR > SLVERR > OKAY).
  - wlast asserted before the final beat, or deasserted on it, gives bresp=SLVERR (2'b10) if no DECERR occurred. Data is still written.
- Same-cycle read and write to the same word: the read returns the old data (read-before-write).
- The read and write paths are fully independent; both may be active simultaneously.

Decomposition:
- Package axi_mem_pkg holds:
  - resp constants RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - burst constants BURST_FIXED/INCR/WRAP;
  - enum typedefs wr_state_t {W_IDLE,W_DATA,W_RESP} and rd_state_t {R_IDLE,R_DATA};
  - function worst_resp().
- Sub-module axi_mem_array: simple dual-port RAM with one byte-enable write port and one registered read port, read-before-write, MEM_DEPTH x DATA_W.

Test Plan:
- Write then read single beat: AW addr=0x10, len=0, data=0xDEADBEEF, strb=0xF -> bresp=OKAY. AR addr=0x10 -> rdata=0xDEADBEEF, rlast=1, rresp=OKAY, rid equals arid.
- INCR burst of 4 with strobes: AW addr=0x100, len=3, data=0x11111111..0x44444444, beat 2 strb=0x3. Pre-fill that word with 0xFFFFFFFF -> readback 0x11111111, 0x22222222, 0xFFFF3333, 0x44444444.
- Backpressure: read len=7 with rready toggling every cycle -> rdata/rlast stable while stalled, exactly 8 beats, rlast only on the 8th.
- Out of range and WRAP: write at byte 0x1000 (DEPTH=1024, 32-bit) -> DECERR, memory unchanged. WRAP read len=3 -> 4 beats, all SLVERR.
- Protocol error: 2-beat write with wlast on beat 1 -> bresp=SLVERR, both words written, FSM returns to W_IDLE.
- Concurrency and reset: simultaneous write/read to 0x20 (old value 0xA5A5A5A5, new 0x5A5A5A5A) -> read returns 0xA5A5A5A5. Assert areset during beat 2 of a 4-beat read -> rvalid=0 next cycle, arready=1, new read then succeeds.

Source files
------------

// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_pkg
//  Description : Shared response/burst codes, FSM state types and the
//                response-merge helper for the AXI4 memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Merge two response codes, keeping the more severe one
    // (DECERR > SLVERR > EXOKAY > OKAY).
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        if (a == RESP_DECERR || b == RESP_DECERR)      r = RESP_DECERR;
        else if (a == RESP_SLVERR || b == RESP_SLVERR) r = RESP_SLVERR;
        else if (a == RESP_EXOKAY || b == RESP_EXOKAY) r = RESP_EXOKAY;
        else                                           r = RESP_OKAY;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_array
//  Description : Simple dual-port RAM, MEM_DEPTH x DATA_W. One byte-enable
//                write port and one registered read port; a read and write
//                of the same word in one cycle returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_array #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int ADR_W     = $clog2(MEM_DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADR_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [ADR_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write: only strobed lanes of the addressed word change.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_slave
//  Description : AXI4 memory-mapped responder. Independent write and read
//                engines, one outstanding burst per direction, serviced from
//                an internal byte-addressable memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int          OFF     = $clog2(DATA_W / 8);
    localparam int          IDX_W   = ADDR_W - OFF;
    localparam int          MA_W    = $clog2(MEM_DEPTH);
    localparam logic [31:0] DEPTH_U = MEM_DEPTH;

    // Word index lies inside the memory.
    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {{(32-IDX_W){1'b0}}, idx} < DEPTH_U;
    endfunction

    // Response for one beat from burst type and word index alone.
    function automatic logic [1:0] beat_resp(input logic [1:0] burst, input logic [IDX_W-1:0] idx);
        logic [1:0] r;
        case (burst)
            BURST_FIXED, BURST_INCR: r = RESP_OKAY;
            BURST_WRAP:              r = RESP_SLVERR;
            default:                 r = RESP_SLVERR;
        endcase
        if (!in_range(idx)) r = worst_resp(r, RESP_DECERR);
        return r;
    endfunction

    // Word index of the following beat.
    function automatic logic [IDX_W-1:0] next_idx(input logic [1:0] burst, input logic [IDX_W-1:0] idx);
        return (burst == BURST_INCR) ? idx + IDX_W'(1) : idx;
    endfunction

    // ---------------------------------------------------------------- write
    wr_state_t         wr_state_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bresp_q, wr_acc_q, wr_burst_q;
    logic [ID_W-1:0]   bid_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [7:0]        wr_len_q, wr_cnt_q;

    logic              w_hs, wr_last_beat, mem_we;
    logic [1:0]        wr_beat_resp, wr_acc_d;

    // Per-beat write qualification and running worst-case response.
    always_comb begin
        w_hs         = (wr_state_q == W_DATA) && wvalid && wready_q;
        wr_last_beat = (wr_cnt_q == wr_len_q);
        wr_beat_resp = beat_resp(wr_burst_q, wr_idx_q);
        if (wlast != wr_last_beat) begin
            wr_beat_resp = worst_resp(wr_beat_resp, RESP_SLVERR);
        end
        wr_acc_d     = worst_resp(wr_acc_q, wr_beat_resp);
        mem_we       = w_hs && (beat_resp(wr_burst_q, wr_idx_q) == RESP_OKAY);
    end

    // Write FSM: AW accept, beat counting (awlen decides the end), B response.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            bid_q      <= '0;
            wr_acc_q   <= RESP_OKAY;
            wr_burst_q <= BURST_INCR;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (awvalid && awready_q) begin
                        bid_q      <= awid;
                        wr_idx_q   <= awaddr[ADDR_W-1:OFF];
                        wr_len_q   <= awlen;
                        wr_burst_q <= awburst;
                        wr_cnt_q   <= '0;
                        wr_acc_q   <= RESP_OKAY;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_idx_q <= next_idx(wr_burst_q, wr_idx_q);
                        wr_cnt_q <= wr_cnt_q + 8'd1;
                        wr_acc_q <= wr_acc_d;
                        if (wr_last_beat) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= wr_acc_d;
                            wr_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_t         rd_state_q;
    logic              arready_q, rvalid_q, rlast_q, rzero_q;
    logic [1:0]        rresp_q, rd_burst_q;
    logic [ID_W-1:0]   rid_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [7:0]        rd_len_q, rd_cnt_q;

    logic              ar_hs, r_adv, rd_re;
    logic [IDX_W-1:0]  ar_idx, rd_idx_d, rd_raddr;
    logic [1:0]        ar_resp, rd_next_resp;
    logic [DATA_W-1:0] mem_rdata;

    // Memory read request: first beat at AR accept, next beat after each
    // non-final R handshake, so the output register holds while stalled.
    always_comb begin
        ar_idx       = araddr[ADDR_W-1:OFF];
        ar_hs        = (rd_state_q == R_IDLE) && arvalid && arready_q;
        r_adv        = (rd_state_q == R_DATA) && rvalid_q && rready && !rlast_q;
        rd_idx_d     = next_idx(rd_burst_q, rd_idx_q);
        ar_resp      = beat_resp(arburst, ar_idx);
        rd_next_resp = beat_resp(rd_burst_q, rd_idx_d);
        rd_re        = ar_hs || r_adv;
        rd_raddr     = ar_hs ? ar_idx : rd_idx_d;
    end

    // Read FSM: AR accept, one registered beat at a time, rlast on beat arlen+1.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rzero_q    <= 1'b1;
            rresp_q    <= RESP_OKAY;
            rid_q      <= '0;
            rd_burst_q <= BURST_INCR;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rid_q      <= arid;
                        rd_idx_q   <= ar_idx;
                        rd_len_q   <= arlen;
                        rd_burst_q <= arburst;
                        rd_cnt_q   <= '0;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rlast_q    <= (arlen == 8'd0);
                        rresp_q    <= ar_resp;
                        rzero_q    <= (ar_resp != RESP_OKAY);
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && rready) begin
                        if (rlast_q) begin
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_d;
                            rd_cnt_q <= rd_cnt_q + 8'd1;
                            rlast_q  <= ((rd_cnt_q + 8'd1) == rd_len_q);
                            rresp_q  <= rd_next_resp;
                            rzero_q  <= (rd_next_resp != RESP_OKAY);
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    axi_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk_i   (aclk),
        .we_i    (mem_we),
        .waddr_i (wr_idx_q[MA_W-1:0]),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .re_i    (rd_re),
        .raddr_i (rd_raddr[MA_W-1:0]),
        .rdata_o (mem_rdata)
    );

    // Sub-word address bits carry no meaning for aligned accesses.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{awaddr[OFF-1:0], araddr[OFF-1:0]};

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign bid     = bid_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;
    assign rdata   = rzero_q ? '0 : mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_slave
//  Description : Scoreboard bench for axi_mem_slave. Stimulus tasks update a
//                word-array reference model and queue expected B/R responses;
//                monitors compare whatever the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slave;

    localparam int DEPTH = 1024;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [15:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [1:0]  awburst = INCR, arburst = INCR, bresp, rresp;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready, arvalid = 1'b0, arready, rvalid, rready, rlast;

    always #5 aclk = ~aclk;

    axi_mem_slave #(.ADDR_W(16), .DATA_W(32), .ID_W(4), .MEM_DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; logic chk; } rexp_t;

    bexp_t       exp_b[$];
    rexp_t       exp_r[$];
    logic [31:0] mdl [0:DEPTH-1];
    logic [31:0] wd [0:255];
    logic [3:0]  ws [0:255];
    int          n_vec = 0, n_err = 0;
    int          rmode = 0, bmode = 0;
    bit          rmon_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        if (a == DECERR || b == DECERR) return DECERR;
        if (a == SLVERR || b == SLVERR) return SLVERR;
        return OKAY;
    endfunction

    // Reference write: apply the spec rules beat by beat, queue the B response.
    task automatic wr_expect(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int bad_last);
        int base = int'(addr) / 4;
        logic [1:0] r = OKAY;
        for (int b = 0; b <= int'(len); b++) begin
            int i = (burst == INCR) ? base + b : base;
            if (i >= DEPTH) r = worse(r, DECERR);
            else if (burst == WRAP || burst == RSVD) r = worse(r, SLVERR);
            else begin
                for (int k = 0; k < 4; k++)
                    if (ws[b][k]) mdl[i][k*8 +: 8] = wd[b][k*8 +: 8];
            end
            if (b == bad_last) r = worse(r, SLVERR);
        end
        exp_b.push_back('{id: id, resp: r});
    endtask

    task automatic rd_expect(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
        int base = int'(addr) / 4;
        for (int b = 0; b <= int'(len); b++) begin
            int i = (burst == INCR) ? base + b : base;
            rexp_t e;
            e.id = id;
            e.last = (b == int'(len));
            if (i >= DEPTH) begin e.resp = DECERR; e.data = '0; e.chk = 1'b1; end
            else if (burst == WRAP || burst == RSVD) begin e.resp = SLVERR; e.data = '0; e.chk = 1'b0; end
            else begin e.resp = OKAY; e.data = mdl[i]; e.chk = 1'b1; end
            exp_r.push_back(e);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
        bit hs = 1'b0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge aclk); hs = awready;
            @(posedge aclk); #1;
        end
        awvalid = 1'b0;
        if (!hs) timeout("aw_handshake");
    endtask

    task automatic w_send(input logic [7:0] len, input int bad_last);
        for (int b = 0; b <= int'(len); b++) begin
            bit hs = 1'b0;
            wdata = wd[b]; wstrb = ws[b];
            wlast = (b == int'(len)) ^ (b == bad_last);
            wvalid = 1'b1;
            for (int c = 0; c < 200 && !hs; c++) begin
                @(negedge aclk); hs = wready;
                @(posedge aclk); #1;
            end
            if (!hs) begin timeout("w_handshake"); break; end
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
        bit hs = 1'b0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge aclk); hs = arready;
            @(posedge aclk); #1;
        end
        arvalid = 1'b0;
        if (!hs) timeout("ar_handshake");
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int bad_last);
        wr_expect(id, addr, len, burst, bad_last);
        aw_send(id, addr, len, burst);
        w_send(len, bad_last);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
        rd_expect(id, addr, len, burst);
        ar_send(id, addr, len, burst);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && c < 5000) begin
            @(posedge aclk); c++;
        end
        repeat (2) @(posedge aclk);
        #1;
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            timeout("response_drain");
            exp_b.delete(); exp_r.delete();
        end
    endtask

    // Ready drivers for the B and R channels.
    initial begin
        rready = 1'b1; bready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = !rready;
                default: rready = 1'($urandom_range(0, 1));
            endcase
            bready = (bmode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // B monitor.
    always @(negedge aclk) begin
        if (!areset && bvalid) begin
            if (exp_b.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL b_unexpected: got bresp %0h expected no response", bresp);
            end else begin
                check("bid", 64'(bid), 64'(exp_b[0].id));
                check("bresp", 64'(bresp), 64'(exp_b[0].resp));
                if (bready) void'(exp_b.pop_front());
            end
        end
    end

    // R monitor: a stalled beat is compared against the same queue head each
    // cycle until accepted.
    always @(negedge aclk) begin
        if (!areset && rmon_en && rvalid) begin
            if (exp_r.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL r_unexpected: got rdata %0h expected no beat", rdata);
            end else begin
                check("rid", 64'(rid), 64'(exp_r[0].id));
                check("rresp", 64'(rresp), 64'(exp_r[0].resp));
                check("rlast", 64'(rlast), 64'(exp_r[0].last));
                if (exp_r[0].chk) check("rdata", 64'(rdata), 64'(exp_r[0].data));
                if (rready) void'(exp_r.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk); #1;

        // Reset state.
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_rlast",   64'(rlast),   64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        check("rst_rresp",   64'(rresp),   64'd0);
        check("rst_rdata",   64'(rdata),   64'd0);
        check("rst_bid",     64'(bid),     64'd0);
        check("rst_rid",     64'(rid),     64'd0);

        // Fill the whole memory with known random contents (256-beat bursts).
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
            wr_burst(4'(p), 16'(p * 1024), 8'd255, INCR, -1);
            wait_idle();
        end

        // Single beat write/read.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        wr_burst(4'h3, 16'h0010, 8'd0, INCR, -1); wait_idle();
        rd_burst(4'h9, 16'h0010, 8'd0, INCR);     wait_idle();

        // INCR burst of 4 with a partial strobe over a pre-filled word.
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
        wr_burst(4'h1, 16'h0108, 8'd0, INCR, -1); wait_idle();
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'h3; ws[3] = 4'hF;
        wr_burst(4'h2, 16'h0100, 8'd3, INCR, -1); wait_idle();
        rd_burst(4'h2, 16'h0100, 8'd3, INCR);     wait_idle();

        // Backpressure: rready toggling every cycle on an 8-beat read.
        rmode = 1;
        rd_burst(4'h7, 16'h0100, 8'd7, INCR); wait_idle();
        rmode = 0;

        // Out of range write/read, then confirm word 0 was not aliased.
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        wr_burst(4'h5, 16'h1000, 8'd0, INCR, -1); wait_idle();
        rd_burst(4'h5, 16'h1000, 8'd0, INCR);     wait_idle();
        rd_burst(4'h6, 16'h0000, 8'd0, INCR);     wait_idle();
        // Burst running off the end of memory.
        for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        wr_burst(4'h4, 16'h0FF8, 8'd3, INCR, -1); wait_idle();
        rd_burst(4'h4, 16'h0FF8, 8'd3, INCR);     wait_idle();

        // WRAP/reserved: no writes, SLVERR everywhere.
        for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
        wr_burst(4'hA, 16'h0200, 8'd1, WRAP, -1); wait_idle();
        wr_burst(4'hB, 16'h0204, 8'd0, RSVD, -1); wait_idle();
        rd_burst(4'hC, 16'h0200, 8'd1, INCR);     wait_idle();
        rd_burst(4'hD, 16'h0200, 8'd3, WRAP);     wait_idle();

        // wlast early, then wlast missing on the final beat.
        wd[0] = 32'h01020304; wd[1] = 32'h05060708; ws[0] = 4'hF; ws[1] = 4'hF;
        wr_burst(4'h8, 16'h0300, 8'd1, INCR, 0); wait_idle();
        wd[0] = 32'h0A0B0C0D; wd[1] = 32'h0E0F1011;
        wr_burst(4'h8, 16'h0308, 8'd1, INCR, 1); wait_idle();
        rd_burst(4'h8, 16'h0300, 8'd3, INCR);    wait_idle();

        // FIXED burst: all beats hit one word.
        for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'(1 << b); end
        wr_burst(4'hE, 16'h0040, 8'd3, FIXED, -1); wait_idle();
        rd_burst(4'hE, 16'h0040, 8'd2, FIXED);     wait_idle();

        // Same-cycle read and write of one word: read sees the old value.
        wd[0] = 32'hA5A5A5A5; ws[0] = 4'hF;
        wr_burst(4'h1, 16'h0020, 8'd0, INCR, -1); wait_idle();
        rd_expect(4'h2, 16'h0020, 8'd0, INCR);
        wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
        wr_expect(4'h3, 16'h0020, 8'd0, INCR, -1);
        aw_send(4'h3, 16'h0020, 8'd0, INCR);
        fork
            w_send(8'd0, -1);
            ar_send(4'h2, 16'h0020, 8'd0, INCR);
        join
        wait_idle();
        rd_burst(4'h4, 16'h0020, 8'd0, INCR); wait_idle();

        // Reset in the middle of a 4-beat read.
        rmon_en = 1'b0;
        ar_send(4'h6, 16'h0080, 8'd3, INCR);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        check("midrst_rvalid",  64'(rvalid),  64'd0);
        check("midrst_arready", 64'(arready), 64'd1);
        check("midrst_awready", 64'(awready), 64'd1);
        rmon_en = 1'b1;
        rd_burst(4'h7, 16'h0080, 8'd3, INCR); wait_idle();

        // Randomized write-then-read pairs with random backpressure.
        for (int t = 0; t < 40; t++) begin
            int          sel = $urandom_range(0, 9);
            logic [1:0]  bt  = (sel == 0) ? FIXED : (sel == 1) ? WRAP : (sel == 2) ? RSVD : INCR;
            logic [7:0]  ln  = 8'($urandom_range(0, 7));
            int          wi  = ($urandom_range(0, 7) == 0 && bt == INCR) ? 1020 + $urandom_range(0, 7)
                                                                         : $urandom_range(0, DEPTH - 1);
            logic [3:0]  id  = 4'($urandom);
            int          bl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(ln)) : -1;
            for (int b = 0; b <= int'(ln); b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
            rmode = $urandom_range(0, 2);
            bmode = $urandom_range(0, 1);
            wr_burst(id, 16'(wi * 4), ln, bt, bl); wait_idle();
            rd_burst(~id, 16'(wi * 4), ln, bt);    wait_idle();
        end
        rmode = 0; bmode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
